// File: rtl/leds_pio_arbiter.sv
// Round-robin arbiter that lets several requesters share the LED PIO slave.
// Each winner gets one write, one verify read and a single-cycle grant pulse.
module leds_pio_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 14
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [1:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [31:0]               avm_writedata,
    input  logic [31:0]               avm_readdata,
    output logic                      busy,
    output logic [2:0]                owner,
    output logic                      verify_err,
    input  logic                      err_clr
);

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

    state_t              state, state_d;
    logic [2:0]          ptr;
    logic [DATA_W-1:0]   data;
    logic                found;
    logic [2:0]          winner;
    logic [DATA_W-1:0]   winner_data;
    logic                cs_d, write_n_d, busy_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic                mismatch;
    int                  idx;

    // Walk from the lowest to the highest priority so the last hit is the winner.
    always_comb begin
        found       = 1'b0;
        winner      = '0;
        winner_data = '0;
        idx         = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + 1 + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                found       = 1'b1;
                winner      = 3'(idx);
                winner_data = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign mismatch = (state == VERIFY) && (avm_readdata[DATA_W-1:0] != data);

    // State register.
    // NOTE: synchronous reset lives inside the clocked block; no reset in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (found) state_d = WRITE;
            WRITE:   state_d = VERIFY;
            VERIFY:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so every bus output comes straight off a flop.
    always_comb begin
        cs_d      = (state_d == WRITE) || (state_d == VERIFY);
        write_n_d = (state_d != WRITE);
        busy_d    = (state_d != IDLE);
        grant_d   = '0;
        if (state_d == DONE) grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            grant          <= '0;
            busy           <= 1'b0;
            owner          <= '0;
            ptr            <= 3'(NUM_REQ - 1);
            data           <= '0;
            verify_err     <= 1'b0;
        end else begin
            avm_chipselect <= cs_d;
            avm_write_n    <= write_n_d;
            grant          <= grant_d;
            busy           <= busy_d;
            if (state == IDLE && found) begin
                owner         <= winner;
                data          <= winner_data;
                avm_writedata <= 32'(winner_data);
            end
            if (state == VERIFY) ptr <= owner;
            // A fresh mismatch wins over a clear in the same cycle.
            if (mismatch)     verify_err <= 1'b1;
            else if (err_clr) verify_err <= 1'b0;
        end
    end

    assign avm_address = 2'b00;

endmodule

// File: tb/tb_leds_pio_arbiter.sv
// Directed bench for leds_pio_arbiter with a zero-wait PIO register model.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_leds_pio_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 14;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [1:0]                avm_address;
    logic                      avm_chipselect;
    logic                      avm_write_n;
    logic [31:0]               avm_writedata;
    logic [31:0]               avm_readdata;
    logic                      busy;
    logic [2:0]                owner;
    logic                      verify_err;
    logic                      err_clr;

    logic [DATA_W-1:0]         pio_reg = '0;
    logic                      corrupt;
    int                        passed = 0;
    int                        total  = 0;

    always #5 clk = ~clk;

    leds_pio_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_data       (req_data),
        .grant          (grant),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .owner          (owner),
        .verify_err     (verify_err),
        .err_clr        (err_clr)
    );

    // PIO data register: accepts writes, reads back combinationally (or zero when corrupted).
    always @(posedge clk) if (avm_chipselect && !avm_write_n) pio_reg <= avm_writedata[DATA_W-1:0];
    assign avm_readdata = corrupt ? 32'h0 : {18'b0, pio_reg};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] d);
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        err_clr  = 1'b0;
        corrupt  = 1'b0;
        tick();
        tick();
        check("rst_cs",      32'(avm_chipselect), 32'h0);
        check("rst_write_n", 32'(avm_write_n),    32'h1);
        check("rst_wdata",   avm_writedata,       32'h0);
        check("rst_grant",   32'(grant),          32'h0);
        check("rst_busy",    32'(busy),           32'h0);
        check("rst_owner",   32'(owner),          32'h0);
        check("rst_err",     32'(verify_err),     32'h0);
        check("rst_addr",    32'(avm_address),    32'h0);

        // Single request: write at N+1, verify at N+2, grant at N+3.
        reset_n = 1'b1;
        set_data(0, 14'h2A5C);
        req = 4'b0001;
        tick();
        check("t1_w_cs",    32'(avm_chipselect), 32'h1);
        check("t1_w_wn",    32'(avm_write_n),    32'h0);
        check("t1_w_data",  avm_writedata,       32'h00002A5C);
        check("t1_w_busy",  32'(busy),           32'h1);
        tick();
        check("t1_v_cs",    32'(avm_chipselect), 32'h1);
        check("t1_v_wn",    32'(avm_write_n),    32'h1);
        check("t1_v_busy",  32'(busy),           32'h1);
        check("t1_v_grant", 32'(grant),          32'h0);
        tick();
        check("t1_d_grant", 32'(grant),          32'h1);
        check("t1_d_cs",    32'(avm_chipselect), 32'h0);
        check("t1_d_busy",  32'(busy),           32'h1);
        check("t1_d_err",   32'(verify_err),     32'h0);
        req = '0;
        tick();
        check("t1_i_grant", 32'(grant),          32'h0);
        check("t1_i_busy",  32'(busy),           32'h0);

        // Fresh pointer, all four requesting: grants 0,1,2,3,0 four cycles apart.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_data(0, 14'h0001);
        set_data(1, 14'h0002);
        set_data(2, 14'h0004);
        set_data(3, 14'h0008);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr%0d_wdata", k), avm_writedata, 32'h1 << (k % 4));
            tick();
            tick();
            check($sformatf("rr%0d_grant", k), 32'(grant), 32'h1 << (k % 4));
            check($sformatf("rr%0d_owner", k), 32'(owner), 32'(k % 4));
            tick();
            check($sformatf("rr%0d_gap", k), 32'(grant), 32'h0);
        end
        req = '0;

        // Readback mismatch sets a sticky flag; err_clr clears it.
        set_data(1, 14'h3FFF);
        corrupt = 1'b1;
        req = 4'b0010;
        tick();
        check("err_wdata", avm_writedata, 32'h00003FFF);
        tick();
        tick();
        check("err_set",   32'(verify_err), 32'h1);
        check("err_grant", 32'(grant),      32'h2);
        req = '0;
        tick();
        tick();
        check("err_hold",  32'(verify_err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr",   32'(verify_err), 32'h0);

        // Mismatch in the same cycle as err_clr: set wins.
        req = 4'b0010;
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        req = '0;
        check("err_prio",  32'(verify_err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        corrupt = 1'b0;
        check("err_clr2",  32'(verify_err), 32'h0);

        // Data is captured at arbitration; dropping req early still completes.
        set_data(2, 14'h1234);
        req = 4'b0100;
        tick();
        set_data(2, 14'h0BAD);
        check("cap_wdata", avm_writedata, 32'h00001234);
        tick();
        req = '0;
        tick();
        check("cap_grant", 32'(grant), 32'h4);
        check("cap_pio",   32'(pio_reg), 32'h00001234);
        tick();

        // Reset during VERIFY aborts; afterwards requester 0 beats requester 3.
        set_data(3, 14'h0155);
        set_data(0, 14'h2A5C);
        req = 4'b1000;
        tick();
        tick();
        check("ab_v_cs",    32'(avm_chipselect), 32'h1);
        reset_n = 1'b0;
        tick();
        check("ab_cs",      32'(avm_chipselect), 32'h0);
        check("ab_wn",      32'(avm_write_n),    32'h1);
        check("ab_grant",   32'(grant),          32'h0);
        check("ab_busy",    32'(busy),           32'h0);
        check("ab_owner",   32'(owner),          32'h0);
        reset_n = 1'b1;
        req = 4'b1001;
        tick();
        check("ab_rr_data", avm_writedata,       32'h00002A5C);
        check("ab_rr_cs",   32'(avm_chipselect), 32'h1);
        tick();
        tick();
        check("ab_rr_gnt",  32'(grant),          32'h1);
        req = '0;
        tick();

        // Quiet bus: no requests, no activity.
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("idle%0d_cs", k),    32'(avm_chipselect), 32'h0);
            check($sformatf("idle%0d_grant", k), 32'(grant),          32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
